uart_msg_sender: RTL
====================

# uart_msg_sender

Parametrised UART message transmitter: on a start request, latches an N-byte message and serialises it byte by byte onto a UART line, then reports completion. It generalises the fixed 8N1 single-shot message emitter: configurable data width, parity, stop bits, inter-byte gap, byte order, and a restartable start/busy/done handshake. It serves as a stimulus source for controller boot benches and as a synthesizable boot-loader feeder.

## Interface
- `clk_freq`, 1000000: clock frequency in Hz.
- `baud_rate`, 9600: line rate; bit period `D = clk_freq / baud_rate` (integer truncation, must be ≥ 2).
- `msg_size_byte`, 6: bytes per message (≥ 1).
- `data_bits`, 8: data bits per frame, 5 to 8.
- `parity`, 0: 0 none, 1 odd, 2 even.
- `stop_bits`, 1: 1 or 2.
- `gap_bits`, 0: idle bit periods inserted after each frame's stop bits (0 to 15).
- `msb_byte_first`, 0: 0 sends `msg[7:0]` first; 1 sends the top byte first.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous reset, active-high.
- `start` in 1: request transmission; sampled only while idle.
- `msg` in `8*msg_size_byte`: message; latched on the accepted start.
- `tx` out 1: UART line, idle high.
- `busy` out 1: high from the cycle after an accepted start until completion.
- `done` out 1: one-cycle completion pulse.
- `byte_index` out `$clog2(msg_size_byte+1)`: index of the byte currently on the line, in send order.

## Operation
- States: IDLE, START_BIT, DATA, PARITY, STOP, GAP.
- **IDLE:** `tx=1`, `busy=0`. If `start=1`, latch `msg`, clear the byte counter, and go to START_BIT.
- **START_BIT:** `tx=0` for D cycles, then go to DATA.
- **DATA:** send the low `data_bits` bits of the current byte, LSB first, D cycles each. Unused upper bits are ignored. Next state is PARITY if `parity≠0`, else STOP.
- **PARITY:** `tx` = XOR of the sent data bits (even), or its inverse (odd), for D cycles.
- **STOP:** `tx=1` for `stop_bits·D` cycles. Next state is GAP if `gap_bits>0`. Otherwise go to START_BIT with the byte counter incremented, or to IDLE after the last byte.
- **GAP:** `tx=1` for `gap_bits·D` cycles, then apply the same next-byte/IDLE decision as STOP.
- **Byte selection:** with `msb_byte_first=0`, byte k is `msg[8k+7:8k]`. With `msb_byte_first=1`, byte k is `msg[8(N-1-k)+7:8(N-1-k)]`.
- **Start while busy:** `start` is ignored and the latched message is unaffected.
- **Reset mid-frame:** the next cycle has `tx=1`, `busy=0`, `done=0`, `byte_index=0`, state IDLE. The partial frame is abandoned.
- **Reset values:** `tx=1`, `busy=0`, `done=0`, `byte_index=0`.

## Timing
- All outputs are registered.
- Accepted start at edge t: `tx` falls and `busy` rises at t+1.
- Every bit lasts exactly D cycles. A bit counter reloads at each bit boundary, so there is no cumulative drift.
- Frame length `F = (1 + data_bits + (parity≠0) + stop_bits + gap_bits)·D`.
- At the end of the final frame: state returns to IDLE, `busy` falls, and `done=1` for exactly one cycle. That cycle is t+1+N·F.
- A `start` on the `done` cycle is accepted: `tx` falls the next cycle, so back-to-back messages have no extra idle.
- `byte_index` increments on the first cycle of each start bit after the first byte.

## Structure
- **Shared package `uart_pkg`:** the state encoding and parity constants (`PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`). The receiver side reuses both.
- **Sub-module `uart_baud_tick`:** parametrised by D. It provides a `restart` input and a one-cycle `tick` output every D cycles. The FSM counts ticks per state.

## Test plan
- **8N1, basic message:** D=10, N=6, `msg=48'hE8E901020304`, start pulse. Decoding `tx` yields 04,03,02,01,E9,E8. `done` is high at cycle 1+6·100 after start, and `busy` falls on that same cycle.
- **7E2 with gap:** `data_bits=7`, `parity=2`, `stop_bits=2`, `gap_bits=3`, `msg=16'h41FF`. Frames carry 7F with parity 1, then 41 with parity 0. Each frame is 14·D cycles, and `tx` stays high through the gap.
- **Odd parity, MSB-first:** `msb_byte_first=1`, `parity=1`, `msg=16'h0080`. Frame order is 00 (parity 1), then 80 (parity 0).
- **Start during busy:** a second start mid-message with a different `msg` is ignored. The original bytes are sent and `done` pulses once.
- **Restart on done:** asserting `start` on the `done` cycle makes `tx` fall next cycle, with no idle bit between messages.
- **Reset mid-frame:** asserting `reset` during DATA of byte 2 gives `tx=1`, `busy=0`, `byte_index=0` the next cycle. A new start then sends from byte 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and parity helper shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Wide enough for 8 data bits, 2 stop bits or 15 gap bits.
  localparam int unsigned BIT_CNT_W = 4;

  function automatic logic parity_bit(input logic [7:0] data, input logic [7:0] mask,
                                      input int unsigned mode);
    logic x;
    x = ^(data & mask);
    return (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_msg_sender_if.sv
// uart_msg_sender_if: start/message request and UART line/status outputs of the message sender.
interface uart_msg_sender_if #(
  parameter int unsigned msg_size_byte = 6
) ();
  localparam int unsigned IDX_W = $clog2(msg_size_byte + 1);

  logic                       start;
  logic [8*msg_size_byte-1:0] msg;
  logic                       tx;
  logic                       busy;
  logic                       done;
  logic [IDX_W-1:0]           byte_index;

  modport master (output start, msg, input tx, busy, done, byte_index);
  modport slave  (input start, msg, output tx, busy, done, byte_index);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick on the last cycle of every bit_period-cycle bit; restart realigns it.
module uart_baud_tick #(
  parameter int unsigned bit_period = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int unsigned CNT_W = $clog2(bit_period);

  logic [CNT_W-1:0] cnt_q;

  // Tick is registered one count early so it coincides with the bit's final cycle.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_W'(bit_period - 1)) ? '0 : cnt_q + CNT_W'(1);
      tick  <= (cnt_q == CNT_W'(bit_period - 2));
    end
  end
endmodule

// File: rtl/uart_msg_sender.sv
// uart_msg_sender: latches an N-byte message on start and serialises it as UART frames.
// Data width, parity, stop/gap bits and byte order are set by parameters.
module uart_msg_sender
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq       = 1000000,
  parameter int unsigned baud_rate      = 9600,
  parameter int unsigned msg_size_byte  = 6,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity         = 0,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned gap_bits       = 0,
  parameter int unsigned msb_byte_first = 0
) (
  input logic              clk,
  input logic              reset,
  uart_msg_sender_if.slave bus
);
  localparam int unsigned BIT_PERIOD = clk_freq / baud_rate;
  localparam int unsigned MSG_W      = 8 * msg_size_byte;
  localparam int unsigned IDX_W      = $clog2(msg_size_byte + 1);

  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(data_bits - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(stop_bits - 1);
  localparam logic [BIT_CNT_W-1:0] GAP_LAST  = BIT_CNT_W'((gap_bits == 0) ? 32'd0 : gap_bits - 1);
  localparam logic [IDX_W-1:0]     BYTE_LAST = IDX_W'(msg_size_byte - 1);
  localparam logic [7:0]           DATA_MASK = 8'((32'd1 << data_bits) - 32'd1);

  uart_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [MSG_W-1:0]     msg_q, msg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 restart_c;
  logic                 frame_end_c;
  logic [7:0]           cur_byte_c;
  logic                 tick;

  // Send-order index k maps to a byte lane according to the configured byte order.
  function automatic logic [7:0] byte_sel(input logic [MSG_W-1:0] m, input logic [IDX_W-1:0] k);
    int unsigned pos;
    pos = (msb_byte_first != 0) ? (msg_size_byte - 1 - 32'(k)) : 32'(k);
    return 8'(m >> (32'd8 * pos));
  endfunction

  uart_baud_tick #(.bit_period(BIT_PERIOD)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      msg_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      msg_q      <= msg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    msg_d       = msg_q;
    done_d      = 1'b0;
    restart_c   = 1'b0;
    frame_end_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_START_BIT;
          msg_d      = bus.msg;
          byte_idx_d = '0;
          bit_cnt_d  = '0;
          restart_c  = 1'b1;
        end
      end
      ST_START_BIT: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (parity != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (gap_bits != 0) state_d = ST_GAP;
            else               frame_end_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (bit_cnt_q == GAP_LAST) begin
            bit_cnt_d   = '0;
            frame_end_c = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Either start the next byte immediately or finish the message.
    if (frame_end_c) begin
      if (byte_idx_q == BYTE_LAST) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d    = ST_START_BIT;
        byte_idx_d = byte_idx_q + IDX_W'(1);
      end
    end

    cur_byte_c = byte_sel(msg_d, byte_idx_d);

    // Line level is registered from the next state so tx changes on the state boundary.
    case (state_d)
      ST_START_BIT: tx_d = 1'b0;
      ST_DATA:      tx_d = 1'(cur_byte_c >> bit_cnt_d);
      ST_PARITY:    tx_d = parity_bit(cur_byte_c, DATA_MASK, parity);
      default:      tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.byte_index = byte_idx_q;
endmodule
